bnn_result_fifo: RTL and testbench

- Buffers classification results from the BNN core and serves them to the SPI slave, which pulls one result per SPI byte.
- Sits directly upstream of the SPI slave's io_bnn_read / io_bnn_data / io_bnn_empty interface and replaces the stub result generator on the board top.
- Each entry is a 10-bit one-hot class vector. The SPI slave encodes the vector to a class index; any non-one-hot vector becomes 0.

---
 rtl/bnn_result_fifo.sv | 109 ++++++++++
 tb/tb_bnn_result_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bnn_result_fifo.sv
// Result FIFO between the BNN core and the SPI slave.
// Circular buffer with a registered pop output, occupancy count and sticky error flags.
module bnn_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_in_valid,
  input  logic [WIDTH-1:0]         io_in_data,
  output logic                     io_in_ready,
  input  logic                     io_bnn_read,
  output logic [WIDTH-1:0]         io_bnn_data,
  output logic                     io_bnn_empty,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic                     io_overflow,
  output logic                     io_underflow,
  output logic                     io_bad_class,
  input  logic                     io_clear_flags
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             bad_class_q, bad_class_d;

  logic full_c, empty_c, wr_en_c, rd_en_c, in_onehot_c;

  assign full_c      = (count_q == CNT_W'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign wr_en_c     = io_in_valid && !full_c;
  assign rd_en_c     = io_bnn_read && !empty_c;
  assign in_onehot_c = (io_in_data != '0) &&
                       ((io_in_data & (io_in_data - WIDTH'(1))) == '0);

  // Next-state for pointers, count, output data and sticky flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_d      = data_q;
    overflow_d  = overflow_q && !io_clear_flags;
    underflow_d = underflow_q && !io_clear_flags;
    bad_class_d = bad_class_q && !io_clear_flags;

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!in_onehot_c) bad_class_d = 1'b1;
    end
    if (io_in_valid && full_c) overflow_d = 1'b1;

    if (io_bnn_read) begin
      if (rd_en_c) begin
        data_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        data_d      = '0;
        underflow_d = 1'b1;
      end
    end

    case ({wr_en_c, rd_en_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      bad_class_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      bad_class_q <= bad_class_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_c && !reset) mem_q[wr_ptr_q] <= io_in_data;
  end

  assign io_in_ready  = !full_c;
  assign io_bnn_empty = empty_c;
  assign io_bnn_data  = data_q;
  assign io_count     = count_q;
  assign io_overflow  = overflow_q;
  assign io_underflow = underflow_q;
  assign io_bad_class = bad_class_q;

endmodule

// File: tb/tb_bnn_result_fifo.sv
// Scoreboard bench for bnn_result_fifo: stimulus queues expected pop data,
// a monitor compares io_bnn_data the cycle after every read.
module tb_bnn_result_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_in_valid;
  logic [9:0] io_in_data;
  logic       io_in_ready;
  logic       io_bnn_read;
  logic [9:0] io_bnn_data;
  logic       io_bnn_empty;
  logic [2:0] io_count;
  logic       io_overflow;
  logic       io_underflow;
  logic       io_bad_class;
  logic       io_clear_flags;

  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_q[$];
  logic [9:0] mdl[$];
  logic       m_ovf, m_udf, m_bad;

  always #5 clk = ~clk;

  bnn_result_fifo #(.DEPTH(4), .WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_data(io_in_data), .io_in_ready(io_in_ready),
    .io_bnn_read(io_bnn_read), .io_bnn_data(io_bnn_data), .io_bnn_empty(io_bnn_empty),
    .io_count(io_count), .io_overflow(io_overflow), .io_underflow(io_underflow),
    .io_bad_class(io_bad_class), .io_clear_flags(io_clear_flags)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every non-reset read produces a value one cycle later.
  initial begin
    logic rd, rst;
    logic [9:0] e;
    forever begin
      @(posedge clk);
      rd  = io_bnn_read;
      rst = reset;
      #1;
      if (rd && !rst) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_data: got %0h with no expected entry", io_bnn_data);
        end else begin
          e = exp_q.pop_front();
          if (io_bnn_data !== e) begin
            failures++;
            $display("FAIL pop_data: got %0h expected %0h at %0t", io_bnn_data, e, $time);
          end
        end
      end
    end
  end

  // One clock of stimulus starting at a negedge; updates the behavioural model.
  task automatic step(input logic v, input logic [9:0] d, input logic r,
                      input logic clr, input logic rst);
    bit was_full, was_empty;
    io_in_valid = v; io_in_data = d; io_bnn_read = r;
    io_clear_flags = clr; reset = rst;
    if (rst) begin
      mdl.delete();
      m_ovf = 0; m_udf = 0; m_bad = 0;
    end else begin
      was_full  = (mdl.size() == 4);
      was_empty = (mdl.size() == 0);
      if (clr) begin m_ovf = 0; m_udf = 0; m_bad = 0; end
      if (r) begin
        if (was_empty) begin exp_q.push_back(10'h000); m_udf = 1; end
        else exp_q.push_back(mdl.pop_front());
      end
      if (v) begin
        if (was_full) m_ovf = 1;
        else begin
          mdl.push_back(d);
          if ($countones(d) != 1) m_bad = 1;
        end
      end
    end
    @(negedge clk);
    io_in_valid = 0; io_in_data = '0; io_bnn_read = 0;
    io_clear_flags = 0; reset = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, int'(io_count), mdl.size());
    chk({tag, ".empty"}, int'(io_bnn_empty), int'(mdl.size() == 0));
    chk({tag, ".ready"}, int'(io_in_ready), int'(mdl.size() != 4));
    chk({tag, ".ovf"}, int'(io_overflow), int'(m_ovf));
    chk({tag, ".udf"}, int'(io_underflow), int'(m_udf));
    chk({tag, ".bad"}, int'(io_bad_class), int'(m_bad));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] wrv [4];
    wrv[0] = 10'h001; wrv[1] = 10'h002; wrv[2] = 10'h100; wrv[3] = 10'h040;
    io_in_valid = 0; io_in_data = '0; io_bnn_read = 0; io_clear_flags = 0; reset = 1;
    m_ovf = 0; m_udf = 0; m_bad = 0;
    @(negedge clk);
    step(0, '0, 0, 0, 1);
    check_state("reset");
    chk("reset.data", int'(io_bnn_data), 0);

    // Single write then read
    step(1, 10'h004, 0, 0, 0);
    chk("w1.count", int'(io_count), 1);
    chk("w1.empty", int'(io_bnn_empty), 0);
    step(0, '0, 1, 0, 0);
    chk("r1.data", int'(io_bnn_data), 10'h004);
    chk("r1.empty", int'(io_bnn_empty), 1);
    chk("r1.count", int'(io_count), 0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 4; i++) step(1, wrv[i], 0, 0, 0);
    chk("full.ready", int'(io_in_ready), 0);
    chk("full.count", int'(io_count), 4);
    step(1, 10'h200, 0, 0, 0);
    chk("ovf.flag", int'(io_overflow), 1);
    chk("ovf.count", int'(io_count), 4);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);
    chk("drain.empty", int'(io_bnn_empty), 1);
    check_state("drain");

    // Simultaneous read/write while full: write dropped, count DEPTH-1
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 10'h001 << i, 0, 0, 0);
    step(1, 10'h080, 1, 0, 0);
    chk("fullrw.count", int'(io_count), 3);
    chk("fullrw.ovf", int'(io_overflow), 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
    check_state("fullrw");

    // Interleaved traffic, 3*DEPTH entries with pointer wrap
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 10'h001 << (i % 10), (i >= 2) && (i % 3 != 0), 0, 0);
      chk("wrap.count", int'(io_count), mdl.size());
      if (io_count > 3'd4) chk("wrap.bound", int'(io_count), 4);
    end
    while (mdl.size() != 0) step(0, '0, 1, 0, 0);
    check_state("wrap");

    // Underflow and flag clear priority
    step(0, '0, 1, 0, 0);
    chk("udf.data", int'(io_bnn_data), 0);
    chk("udf.flag", int'(io_underflow), 1);
    step(0, '0, 0, 1, 0);
    chk("udf.clear", int'(io_underflow), 0);
    step(0, '0, 1, 1, 0);
    chk("udf.setwins", int'(io_underflow), 1);
    // Empty simultaneous read/write: no bypass
    step(1, 10'h010, 1, 0, 0);
    chk("emptyrw.count", int'(io_count), 1);
    chk("emptyrw.data", int'(io_bnn_data), 0);
    step(0, '0, 1, 1, 0);
    check_state("emptyrw");

    // Non-one-hot entries are stored and flagged
    step(1, 10'h003, 0, 0, 0);
    chk("bad.flag", int'(io_bad_class), 1);
    step(1, 10'h000, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("bad.r0", int'(io_bnn_data), 10'h003);
    step(0, '0, 1, 0, 0);
    chk("bad.r1", int'(io_bnn_data), 10'h000);
    check_state("bad");

    // Reset during simultaneous read/write with entries present
    step(1, 10'h008, 0, 0, 0);
    step(1, 10'h010, 0, 0, 0);
    step(1, 10'h020, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("prerst.data", int'(io_bnn_data), 10'h008);
    step(1, 10'h040, 1, 0, 1);
    check_state("midrst");
    chk("midrst.data", int'(io_bnn_data), 0);

    step(0, '0, 0, 0, 0);
    chk("scoreboard.left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
